score_display: RTL
==================

// Module: score_display
// PURPOSE
// - Consumer end of the game's score_count output: converts the 6-bit binary score to BCD and
//   drives a 4-digit multiplexed, active-low seven-segment display.
// - Sits between the game FSM and the board display pins; sole owner of seg/an/dp.
// - Sequential double-dabble converter, refresh scanner, registered pin drivers.
// PARAMETERS
// - SCORE_W      6           score width; max displayable value 2**SCORE_W-1 (63)
// - REFRESH_DIV  100000      clk cycles per digit slot (1 kHz slot rate at 100 MHz)
// - WIN_SCORE    32          end-of-game score; used only by the optional flash feature
// - FLASH_DIV    25000000    clk cycles per flash half-period (optional feature only)
// PORTS
// - clk          in   1        system clock, all logic on rising edge
// - reset        in   1        asynchronous, active-low reset
// - score        in   SCORE_W  binary score from game; may change on any cycle
// - seg          out  7        {g,f,e,d,c,b,a}, active-low segment drive
// - an           out  4        digit anodes, active-low; an[0] = ones digit
// - dp           out  1        decimal point, active-low; held 1 (off)
// BEHAVIOUR
// - Reset (reset==0, immediate, no clk needed): seg=7'h7F, an=4'hF, dp=1, converter IDLE,
//   shown BCD=00, refresh counter=0, digit index=0, need_conv=1, flash phase=on.
// - Converter FSM: IDLE -> CONV -> LOAD -> IDLE.
//   - IDLE: start when need_conv==1 or score != last_score; capture score into shift reg and last_score.
//   - CONV: exactly SCORE_W cycles; each cycle add 3 to any BCD nibble >=5, then shift left 1.
//   - LOAD: copy tens/ones nibbles to shown register in one cycle (atomic); clear need_conv.
//   - Latency: score change to shown register update = SCORE_W+2 cycles.
//   - Score changes during CONV/LOAD are ignored until IDLE; then reconverted. No mixed values.
// - Scanner: refresh counter 0..REFRESH_DIV-1; on wrap, digit index increments mod 4 (0,1,2,3,0).
// - Pin registers update on the cycle after the index changes:
//   - idx0: an=4'b1110, seg=ones pattern.
//   - idx1: an=4'b1101, seg=tens pattern; if tens==0, an=4'hF and seg=7'h7F (leading-zero blank).
//   - idx2, idx3: an=4'hF, seg=7'h7F (unused digits; duty cycle kept uniform).
// - Patterns 0-9: 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,0000000,0010000.
// - Score 0 shows a single "0" on the ones digit.
// - Only the shown register feeds the pins; the converter working state never does.
// CONFIGURATION
// - SCORE_FLASH_EN defined:
//   - While shown value == WIN_SCORE, flash counter toggles the phase every FLASH_DIV cycles.
//   - Off phase forces an=4'hF and seg=7'h7F. Scanning continues underneath.
//   - When shown value != WIN_SCORE: flash counter is held at 0 and phase is held on.
// - SCORE_FLASH_EN undefined: no flash logic; display is steady for all scores; FLASH_DIV and
//   WIN_SCORE are unused.
// TESTING
// - Reset held low -> an=4'hF, seg=7'h7F, dp=1 with no clk edge required. Release with score=0
//   -> ones=1000000 after 8 cycles; idx1 slot shows an=4'hF.
// - REFRESH_DIV=4, score=17 -> an cycles 1110,1101,1111,1111, each 4 cycles.
//   seg=1111000 in the an[0] slot, seg=1111001 in the an[1] slot.
// - score=5, then 42 two cycles later -> shown 05 at cycle 8, then 42 by cycle 16.
//   Shown register never holds 02 or 45.
// - score=63 -> tens=0000010, ones=0110000. score=9 -> tens blanked, ones=0010000.
// - Reset asserted mid-CONV between clk edges -> pins blank at once.
//   After release, current score is reconverted and shown after SCORE_W+2 cycles.
// - SCORE_FLASH_EN, FLASH_DIV=8, score=32 -> 8 cycles scanning, 8 cycles all dark, repeating.
//   score=31 -> steady. Without the macro, score=32 -> steady.

Source files
------------

// File: rtl/score_display.sv
// score_display: binary score -> BCD via sequential double-dabble, multiplexed onto a 4-digit
// active-low seven-segment display. Define SCORE_FLASH_EN to flash the display at WIN_SCORE.
module score_display #(
    parameter int unsigned SCORE_W     = 6,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned WIN_SCORE   = 32,
    parameter int unsigned FLASH_DIV   = 25000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    output logic [6:0]         seg,
    output logic [3:0]         an,
    output logic               dp
);
    localparam int unsigned WorkW = SCORE_W + 8;
    localparam int unsigned BitW  = $clog2(SCORE_W + 1);
    localparam int unsigned RefW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [BitW-1:0] LastBit = BitW'(SCORE_W - 1);
    localparam logic [RefW-1:0] RefMax  = RefW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {StIdle, StConv, StLoad} conv_state_e;

    conv_state_e        state_q, state_d;
    logic [WorkW-1:0]   work_q, work_d;
    logic [BitW-1:0]    bit_q, bit_d;
    logic [SCORE_W-1:0] last_score_q, last_score_d;
    logic               need_conv_q, need_conv_d;
    logic [7:0]         shown_q, shown_d;
    logic [3:0]         tens_adj, ones_adj;
    logic [RefW-1:0]    ref_q, ref_d;
    logic [1:0]         idx_q, idx_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // Work register layout: {tens, ones, remaining binary bits}
    always_comb begin
        tens_adj = work_q[WorkW-1 -: 4];
        ones_adj = work_q[WorkW-5 -: 4];
        if (tens_adj >= 4'd5) tens_adj = tens_adj + 4'd3;
        if (ones_adj >= 4'd5) ones_adj = ones_adj + 4'd3;
    end

    always_comb begin
        state_d      = state_q;
        work_d       = work_q;
        bit_d        = bit_q;
        last_score_d = last_score_q;
        need_conv_d  = need_conv_q;
        shown_d      = shown_q;
        unique case (state_q)
            StIdle: begin
                if (need_conv_q || (score != last_score_q)) begin
                    work_d       = {8'h00, score};
                    last_score_d = score;
                    bit_d        = '0;
                    state_d      = StConv;
                end
            end
            StConv: begin
                work_d = {tens_adj[2:0], ones_adj, work_q[SCORE_W-1:0], 1'b0};
                bit_d  = bit_q + BitW'(1);
                if (bit_q == LastBit) state_d = StLoad;
            end
            StLoad: begin
                // Both digits land together so the pins never see a half-updated value
                shown_d     = work_q[WorkW-1 -: 8];
                need_conv_d = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ref_d = ref_q + RefW'(1);
        idx_d = idx_q;
        if (ref_q == RefMax) begin
            ref_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

`ifdef SCORE_FLASH_EN
    localparam int unsigned FlashW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [FlashW-1:0] FlashMax = FlashW'(FLASH_DIV - 1);
    localparam logic [7:0] WinBcd = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

    logic [FlashW-1:0] flash_cnt_q, flash_cnt_d;
    logic              flash_on_q, flash_on_d;

    always_comb begin
        flash_cnt_d = '0;
        flash_on_d  = 1'b1;
        if (shown_q == WinBcd) begin
            flash_on_d  = flash_on_q;
            flash_cnt_d = flash_cnt_q + FlashW'(1);
            if (flash_cnt_q == FlashMax) begin
                flash_cnt_d = '0;
                flash_on_d  = ~flash_on_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flash_cnt_q <= '0;
            flash_on_q  <= 1'b1;
        end else begin
            flash_cnt_q <= flash_cnt_d;
            flash_on_q  <= flash_on_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{WIN_SCORE, FLASH_DIV};
`endif

    // Idle slots 2 and 3 stay dark so the lit digits keep a uniform duty cycle
    always_comb begin
        seg_d = 7'h7F;
        an_d  = 4'hF;
        case (idx_q)
            2'd0: begin
                an_d  = 4'b1110;
                seg_d = seg_pattern(shown_q[3:0]);
            end
            2'd1: begin
                if (shown_q[7:4] != 4'd0) begin
                    an_d  = 4'b1101;
                    seg_d = seg_pattern(shown_q[7:4]);
                end
            end
            default: ;
        endcase
`ifdef SCORE_FLASH_EN
        if (!flash_on_q) begin
            seg_d = 7'h7F;
            an_d  = 4'hF;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            work_q       <= '0;
            bit_q        <= '0;
            last_score_q <= '0;
            need_conv_q  <= 1'b1;
            shown_q      <= 8'h00;
            ref_q        <= '0;
            idx_q        <= 2'd0;
            seg_q        <= 7'h7F;
            an_q         <= 4'hF;
        end else begin
            state_q      <= state_d;
            work_q       <= work_d;
            bit_q        <= bit_d;
            last_score_q <= last_score_d;
            need_conv_q  <= need_conv_d;
            shown_q      <= shown_d;
            ref_q        <= ref_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = 1'b1;

endmodule
